// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported, 1-cycle-latency BRAM between the fetch (I) and memory (D) stages.
// D wins by default; a saturating counter forces a waiting fetch through after STARVE_MAX D grants.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic                  i_kill,
    output logic                  i_ack,
    output logic [DATA_W-1:0]     i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_be,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_ack,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  mem_en,
    output logic [DATA_W/8-1:0]   mem_we,
    output logic [ADDR_W-3:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  stall_i,
    output logic                  stall_d
);

    localparam int                CNT_W      = 4;
    localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);

    logic             i_out_q, i_out_d;
    logic             d_out_q, d_out_d;
    logic             kill_pend_q, kill_pend_d;
    logic             d_rd_q, d_rd_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    logic elig_i_s, elig_d_s, gnt_i_s, gnt_d_s;
    logic unused_addr_lsb_s;

    // Per-cycle grant; nothing is granted while reset is asserted
    always_comb begin
        elig_i_s = i_req & ~i_out_q & ~i_kill;
        elig_d_s = d_req & ~d_out_q;
        gnt_i_s  = 1'b0;
        gnt_d_s  = 1'b0;
        if (rst_n == 1'b0) begin
            gnt_i_s = 1'b0;
            gnt_d_s = 1'b0;
        end else if ((starve_cnt_q == STARVE_LIM) && elig_i_s) begin
            gnt_i_s = 1'b1;
        end else if (elig_d_s) begin
            gnt_d_s = 1'b1;
        end else if (elig_i_s) begin
            gnt_i_s = 1'b1;
        end else begin
            gnt_i_s = 1'b0;
            gnt_d_s = 1'b0;
        end
    end

    // Memory command for the granted port; idle bus is driven to zero
    always_comb begin
        mem_en    = gnt_i_s | gnt_d_s;
        mem_addr  = {(ADDR_W-2){1'b0}};
        mem_we    = {(DATA_W/8){1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        if (gnt_d_s) begin
            mem_addr  = d_addr[ADDR_W-1:2];
            mem_wdata = d_wdata;
            mem_we    = d_we ? d_be : {(DATA_W/8){1'b0}};
        end else if (gnt_i_s) begin
            mem_addr  = i_addr[ADDR_W-1:2];
        end else begin
            mem_addr  = {(ADDR_W-2){1'b0}};
        end
    end

    // Next state for in-flight flags and the starvation counter
    always_comb begin
        i_out_d      = gnt_i_s;
        d_out_d      = gnt_d_s;
        kill_pend_d  = gnt_i_s & i_kill;
        d_rd_d       = gnt_d_s & ~d_we;
        starve_cnt_d = starve_cnt_q;
        if (!i_req || gnt_i_s) begin
            starve_cnt_d = {CNT_W{1'b0}};
        end else if (gnt_d_s && elig_i_s && (starve_cnt_q != STARVE_LIM)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i_out_q      <= 1'b0;
            d_out_q      <= 1'b0;
            kill_pend_q  <= 1'b0;
            d_rd_q       <= 1'b0;
            starve_cnt_q <= {CNT_W{1'b0}};
        end else begin
            i_out_q      <= i_out_d;
            d_out_q      <= d_out_d;
            kill_pend_q  <= kill_pend_d;
            d_rd_q       <= d_rd_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Acks land the cycle after the grant; a late kill or reset swallows them
    always_comb begin
        i_ack   = rst_n & i_out_q & ~kill_pend_q & ~i_kill;
        d_ack   = rst_n & d_out_q;
        i_rdata = i_ack ? mem_rdata : {DATA_W{1'b0}};
        d_rdata = (d_ack & d_rd_q) ? mem_rdata : {DATA_W{1'b0}};
        stall_i = i_req & ~i_ack;
        stall_d = d_req & ~d_ack;
    end

    // Byte-offset bits are not used for word addressing
    always_comb begin
        unused_addr_lsb_s = ^{i_addr[1:0], d_addr[1:0]};
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed cycle vectors, then random traffic against a word-level memory model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, i_kill, i_ack;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_ack;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        stall_i, stall_d;

    logic        use_model;
    logic [31:0] tbl_rdata;
    logic [31:0] bram [16];
    logic [31:0] bram_q;
    logic [31:0] ref_mem [16];

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rst_n, ir;
        logic [31:0] ia;
        logic        ik, dr, dw;
        logic [3:0]  be;
        logic [31:0] da, dwd, mr;
        logic        en;
        logic [3:0]  we;
        logic [29:0] ma;
        logic [31:0] mwd;
        logic        iack;
        logic [31:0] ird;
        logic        dack;
        logic [31:0] drd;
        logic        si, sd;
    } vec_t;

    vec_t vq[$];
    vec_t cur;

    mem_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_i(stall_i), .stall_d(stall_d)
    );

    always #5 clk = ~clk;

    assign mem_rdata = use_model ? bram_q : tbl_rdata;

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    // Read-first BRAM with one cycle of read latency
    always @(posedge clk) begin
        if (mem_en) begin
            bram_q <= bram[mem_addr[3:0]];
            bram[mem_addr[3:0]] <= merge(bram[mem_addr[3:0]], mem_wdata, mem_we);
        end
    end

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s [%0d]: got %0h expected %0h", nm, idx, act, exp_v);
        end
    endtask

    task automatic vin(input logic r, input logic ir, input logic [31:0] ia, input logic ik,
                       input logic dr, input logic dw, input logic [3:0] be,
                       input logic [31:0] da, input logic [31:0] dwd, input logic [31:0] mr);
        cur.rst_n = r; cur.ir = ir; cur.ia = ia; cur.ik = ik; cur.dr = dr; cur.dw = dw;
        cur.be = be; cur.da = da; cur.dwd = dwd; cur.mr = mr;
    endtask

    task automatic vexp(input logic en, input logic [3:0] we, input logic [29:0] ma, input logic [31:0] mwd,
                        input logic iack, input logic [31:0] ird, input logic dack, input logic [31:0] drd,
                        input logic si, input logic sd);
        cur.en = en; cur.we = we; cur.ma = ma; cur.mwd = mwd; cur.iack = iack; cur.ird = ird;
        cur.dack = dack; cur.drd = drd; cur.si = si; cur.sd = sd;
        vq.push_back(cur);
    endtask

    task automatic idle();
        vin(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        vexp(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        bit          i_pend, d_pend, i_go;
        int          i_wait, d_wait, d_seq;

        use_model = 1'b0;
        tbl_rdata = '0;
        rst_n = 1'b0; i_req = 1'b0; i_addr = '0; i_kill = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
        repeat (2) @(posedge clk);

        // reset with requests pending
        vin(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        vexp(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        vin(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0, '0, '0);
        vexp(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        // isolated fetch
        vin(1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        vexp(1'b1, '0, 30'h4, '0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        vin(1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0, '0, '0, '0, 32'h13);
        vexp(1'b0, '0, '0, '0, 1'b1, 32'h13, 1'b0, '0, 1'b0, 1'b0);
        vin(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 32'h13);
        vexp(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        // simultaneous I and D: D first, then I
        vin(1'b1, 1'b1, 32'h20, 1'b0, 1'b1, 1'b0, '0, 32'h100, '0, '0);
        vexp(1'b1, '0, 30'h40, '0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        vin(1'b1, 1'b1, 32'h20, 1'b0, 1'b0, 1'b0, '0, '0, '0, 32'h1111_0000);
        vexp(1'b1, '0, 30'h8, '0, 1'b0, '0, 1'b1, 32'h1111_0000, 1'b1, 1'b0);
        vin(1'b1, 1'b1, 32'h20, 1'b0, 1'b0, 1'b0, '0, '0, '0, 32'h2222_0000);
        vexp(1'b0, '0, '0, '0, 1'b1, 32'h2222_0000, 1'b0, '0, 1'b0, 1'b0);
        idle();
        // byte store, then write data gated off when not granted
        vin(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b1, 4'b0010, 32'h204, 32'hAABB_CCDD, '0);
        vexp(1'b1, 4'b0010, 30'h81, 32'hAABB_CCDD, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        vin(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1, 4'hF, '0, 32'hDEAD_BEEF, 32'h5555_5555);
        vexp(1'b0, '0, '0, '0, 1'b0, '0, 1'b1, '0, 1'b0, 1'b0);
        idle();
        // kill in the ack cycle, then redirect
        vin(1'b1, 1'b1, 32'h30, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        vexp(1'b1, '0, 30'hC, '0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        vin(1'b1, 1'b1, 32'h30, 1'b1, 1'b0, 1'b0, '0, '0, '0, 32'h3333);
        vexp(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        vin(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        vexp(1'b1, '0, 30'h10, '0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        vin(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0, '0, '0, '0, 32'h4444);
        vexp(1'b0, '0, '0, '0, 1'b1, 32'h4444, 1'b0, '0, 1'b0, 1'b0);
        idle();
        // starvation: four D grants with I eligible (kills fill the D bubbles), then I is forced
        for (int k = 0; k < 4; k++) begin
            vin(1'b1, 1'b1, 32'h50, 1'b0, 1'b1, 1'b0, '0, 32'h60, '0, '0);
            vexp(1'b1, '0, 30'h18, '0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
            vin(1'b1, 1'b1, 32'h50, 1'b1, 1'b1, 1'b0, '0, 32'h60, '0, 32'h600 + 32'(k));
            vexp(1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 32'h600 + 32'(k), 1'b1, 1'b0);
        end
        vin(1'b1, 1'b1, 32'h50, 1'b0, 1'b1, 1'b0, '0, 32'h60, '0, '0);
        vexp(1'b1, '0, 30'h14, '0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        vin(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 32'h60, '0, 32'h500);
        vexp(1'b1, '0, 30'h18, '0, 1'b1, 32'h500, 1'b0, '0, 1'b0, 1'b1);
        vin(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 32'h604);
        vexp(1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 32'h604, 1'b0, 1'b0);
        // counter back at zero: D wins again
        vin(1'b1, 1'b1, 32'h50, 1'b0, 1'b1, 1'b0, '0, 32'h60, '0, '0);
        vexp(1'b1, '0, 30'h18, '0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        vin(1'b1, 1'b1, 32'h50, 1'b0, 1'b0, 1'b0, '0, '0, '0, 32'h605);
        vexp(1'b1, '0, 30'h14, '0, 1'b0, '0, 1'b1, 32'h605, 1'b1, 1'b0);
        vin(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 32'h501);
        vexp(1'b0, '0, '0, '0, 1'b1, 32'h501, 1'b0, '0, 1'b0, 1'b0);
        // reset mid-read drops the ack; a fresh read then completes normally
        vin(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 32'h70, '0, '0);
        vexp(1'b1, '0, 30'h1C, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        vin(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 32'h70, '0, 32'h7777);
        vexp(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        vin(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        vexp(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        vin(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 32'h70, '0, '0);
        vexp(1'b1, '0, 30'h1C, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        vin(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 32'h7070);
        vexp(1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 32'h7070, 1'b0, 1'b0);
        idle();

        for (int v = 0; v < vq.size(); v++) begin
            @(posedge clk);
            #1;
            rst_n = vq[v].rst_n; i_req = vq[v].ir; i_addr = vq[v].ia; i_kill = vq[v].ik;
            d_req = vq[v].dr; d_we = vq[v].dw; d_be = vq[v].be; d_addr = vq[v].da;
            d_wdata = vq[v].dwd; tbl_rdata = vq[v].mr;
            @(negedge clk);
            chk("mem_en",    v, 64'(mem_en),    64'(vq[v].en));
            chk("mem_we",    v, 64'(mem_we),    64'(vq[v].we));
            chk("mem_addr",  v, 64'(mem_addr),  64'(vq[v].ma));
            chk("mem_wdata", v, 64'(mem_wdata), 64'(vq[v].mwd));
            chk("i_ack",     v, 64'(i_ack),     64'(vq[v].iack));
            chk("i_rdata",   v, 64'(i_rdata),   64'(vq[v].ird));
            chk("d_ack",     v, 64'(d_ack),     64'(vq[v].dack));
            chk("d_rdata",   v, 64'(d_rdata),   64'(vq[v].drd));
            chk("stall_i",   v, 64'(stall_i),   64'(vq[v].si));
            chk("stall_d",   v, 64'(stall_d),   64'(vq[v].sd));
        end

        // random traffic: a write sweep seeds every word, then mixed I/D traffic with kills
        use_model = 1'b1;
        rst_n = 1'b1; i_req = 1'b0; i_kill = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_pend = 1'b0; d_pend = 1'b0; i_go = 1'b0; i_wait = 0; d_wait = 0; d_seq = 0;
        for (int w = 0; w < 16; w++) ref_mem[w] = '0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (i_ack) begin
                chk("rnd_i_ack_valid", cyc, 64'(i_pend & ~i_kill), 64'(1'b1));
                chk("rnd_i_rdata", cyc, 64'(i_rdata), 64'(ref_mem[i_addr[5:2]]));
                i_pend = 1'b0;
            end else begin
                chk("rnd_i_rdata_idle", cyc, 64'(i_rdata), 64'(0));
            end
            if (d_ack) begin
                chk("rnd_d_ack_valid", cyc, 64'(d_pend), 64'(1'b1));
                if (d_we) begin
                    chk("rnd_d_rdata_wr", cyc, 64'(d_rdata), 64'(0));
                    ref_mem[d_addr[5:2]] = merge(ref_mem[d_addr[5:2]], d_wdata, d_be);
                end else begin
                    chk("rnd_d_rdata_rd", cyc, 64'(d_rdata), 64'(ref_mem[d_addr[5:2]]));
                end
                d_pend = 1'b0;
            end else begin
                chk("rnd_d_rdata_idle", cyc, 64'(d_rdata), 64'(0));
            end
            if (i_pend) begin
                i_wait++;
                if (i_wait > 40) begin
                    chk("rnd_i_timeout", cyc, 64'(i_wait), 64'(40));
                    i_pend = 1'b0;
                end
            end
            if (d_pend) begin
                d_wait++;
                if (d_wait > 40) begin
                    chk("rnd_d_timeout", cyc, 64'(d_wait), 64'(40));
                    d_pend = 1'b0;
                end
            end

            if (i_kill) begin
                i_kill = 1'b0;
                i_addr = {26'd0, 4'($urandom_range(15)), 2'b00};
                i_wait = 0;
                i_req  = i_pend;
            end else if (i_pend) begin
                if ($urandom_range(7) == 0) i_kill = 1'b1;
            end else if (i_go && ($urandom_range(1) == 1)) begin
                i_req  = 1'b1;
                i_addr = {26'd0, 4'($urandom_range(15)), 2'b00};
                i_pend = 1'b1;
                i_wait = 0;
            end else begin
                i_req = 1'b0;
            end

            if (!d_pend) begin
                if (d_seq < 16) begin
                    d_req = 1'b1; d_we = 1'b1; d_be = 4'hF;
                    d_addr = {26'd0, 4'(d_seq), 2'b00};
                    d_wdata = $urandom;
                    d_seq++;
                    d_pend = 1'b1;
                    d_wait = 0;
                end else begin
                    i_go = 1'b1;
                    if ($urandom_range(9) < 6) begin
                        d_req = 1'b1;
                        d_we = 1'($urandom_range(1));
                        d_be = 4'($urandom_range(15));
                        d_addr = {26'd0, 4'($urandom_range(15)), 2'b00};
                        d_wdata = $urandom;
                        d_pend = 1'b1;
                        d_wait = 0;
                    end else begin
                        d_req = 1'b0;
                    end
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported synchronous BRAM (1-cycle read latency) between two requesters: the fetch stage (I port, read-only) and the memory stage (D port, read/write).
- Replaces the separate instruction and data memories with a unified memory.
- Arbitrates per cycle: data wins by default, with a starvation guard that protects instruction fetch.
- Drives stall requests into the hazard unit.

Parameters:
ADDR_W, 32, byte address width of both requester ports
DATA_W, 32, data width; byte strobes are DATA_W/8 wide
STARVE_MAX, 4, consecutive D grants with I waiting before I is forced through (range 1..15)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
i_req  in  1  fetch request; held until i_ack
i_addr  in  ADDR_W  fetch byte address; stable while i_req
i_kill  in  1  cancel outstanding fetch (PC redirect)
i_ack  out  1  fetch complete; i_rdata valid
i_rdata  out  DATA_W  fetched word
d_req  in  1  data request; held until d_ack
d_we  in  1  1 = write, 0 = read
d_be  in  DATA_W/8  write byte enables
d_addr  in  ADDR_W  data byte address
d_wdata  in  DATA_W  write data
d_ack  out  1  data access complete
d_rdata  out  DATA_W  load data
mem_en  out  1  memory access this cycle
mem_we  out  DATA_W/8  byte write enables to memory
mem_addr  out  ADDR_W-2  word address (byte address [ADDR_W-1:2])
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en
stall_i  out  1  i_req & ~i_ack
stall_d  out  1  d_req & ~d_ack

Behaviour:
- Outstanding flags:
  - i_out and d_out are set in the cycle after the port is granted, and cleared the following cycle.
  - At most one in-flight transaction exists per port.
- Eligibility in cycle t:
  - elig_i = i_req & ~i_out & ~i_kill
  - elig_d = d_req & ~d_out
- Grant (combinational in cycle t):
  - If starve_cnt == STARVE_MAX and elig_i, grant I.
  - Else if elig_d, grant D.
  - Else if elig_i, grant I.
  - Else no grant.
- Memory drive:
  - mem_en = any grant.
  - mem_addr = granted address[ADDR_W-1:2].
  - mem_we = d_be if D granted and d_we, else 0.
  - mem_wdata = d_wdata, or 0 when not a D grant.
- Acknowledge (registered, cycle t+1):
  - i_ack = i_out & ~kill_pend & ~i_kill.
  - d_ack = d_out.
- Read data:
  - i_rdata = mem_rdata when i_ack, else 0.
  - d_rdata = mem_rdata when d_ack and the granted op was a read, else 0.
  - Writes ack with d_rdata = 0.
- Kill:
  - i_kill during the grant cycle or the ack cycle suppresses i_ack for that fetch.
  - kill_pend latches i_kill in the grant cycle and clears the next cycle.
  - A killed fetch frees the port normally; the requester re-presents its new address.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) when D is granted while elig_i.
  - Clears when I is granted or i_req = 0.
- Requester rules:
  - In its ack cycle the requester may drop req or present a new one.
  - The port is ineligible that cycle (i_out/d_out), so same-port back-to-back issue costs one bubble.
  - Alternating I/D keeps the memory 100% busy.
- Address/data changes while req is held and unacked are protocol violations (behaviour undefined; bench asserts).
- Reset (rst_n = 0 at a clock edge), including mid-transaction:
  - i_out, d_out, kill_pend and starve_cnt go to 0.
  - i_ack and d_ack are 0 and in-flight transactions are dropped with no ack.
  - The combinational outputs follow the inputs; mem_en is forced 0 while rst_n = 0.

Test Plan:
- Isolated fetch: i_req=1, i_addr=0x0000_0010, mem_rdata=0x0000_0013 next cycle -> mem_en=1, mem_addr=0x4 in cycle 0; i_ack=1, i_rdata=0x13 in cycle 1; stall_i=1 in cycle 0 only.
- Simultaneous requests: i_req and d_req (read 0x100) in cycle 0 -> D granted (mem_addr=0x40); I granted in cycle 1 (mem_addr=I word address); d_ack in cycle 1, i_ack in cycle 2.
- Byte store: d_req=1, d_we=1, d_be=4'b0010, d_wdata=0xAABBCCDD, d_addr=0x204 -> mem_we=4'b0010, mem_addr=0x81; d_ack next cycle with d_rdata=0.
- Starvation: d_req held continuously with back-to-back new reads, i_req held, STARVE_MAX=4 -> at most 4 D grants while I is eligible, then I is granted; starve_cnt returns to 0.
- Kill: fetch granted in cycle 0, i_kill=1 in cycle 1 -> i_ack=0 in cycle 1; new i_addr granted in cycle 2, acked in cycle 3 with the correct data.
- Reset mid-read: D granted in cycle 0, rst_n=0 in cycle 1 -> d_ack=0 and mem_en=0 throughout reset; after release, a fresh d_req completes in 2 cycles.
